// File: rtl/seq_udiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_udiv
// Purpose  : Iterative unsigned restoring divider. Retires one quotient bit
//            per clock. Valid/ready handshakes on the operand and result
//            sides.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            in_valid      - operand pair valid
//            in_ready      - block can accept an operand pair (IDLE, no rst)
//            dividend      - DW-bit unsigned dividend
//            divisor       - VW-bit unsigned divisor
//            out_valid     - result valid (registered)
//            out_ready     - consumer accepts the result
//            quotient      - DW-bit quotient
//            remainder     - VW-bit remainder
//            dbz           - divide-by-zero flag for the current result
// Revision : 1.0 - initial release
// ============================================================================
module seq_udiv #(
  parameter int DW = 8,   // dividend / quotient width (DW >= 2)
  parameter int VW = 4    // divisor / remainder width (VW <= DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;

  // r_shift starts as the dividend; each step shifts one dividend bit out
  // of the MSB and one quotient bit into the LSB, so after DW steps it
  // holds the complete quotient.
  logic [DW-1:0] r_shift;
  logic [VW-1:0] r_dvs;
  logic [VW:0]   r_p;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_last;
  logic [VW:0]   w_t;
  logic          w_ge;
  logic [VW:0]   w_p_next;
  logic [DW-1:0] w_q_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  assign w_t      = (VW+1)'({r_p, r_shift[DW-1]});
  assign w_ge     = (w_t >= {1'b0, r_dvs});
  assign w_p_next = w_ge ? (w_t - {1'b0, r_dvs}) : w_t;
  assign w_q_next = {r_shift[DW-2:0], w_ge};
  assign w_last   = (r_cnt == LAST_STEP);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (w_accept) begin
          state_next = (divisor == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (in_ready depends on state and rst only)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = (state == S_IDLE) && !rst;
    w_accept = in_valid && in_ready;
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_dvs     <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= dividend;
            r_dvs   <= divisor;
            r_p     <= '0;
            r_cnt   <= '0;
            // Zero divisor skips iteration: result is ready next cycle.
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              dbz       <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_p     <= w_p_next;
          r_shift <= w_q_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            quotient  <= w_q_next;
            // Final partial remainder is below the divisor, so it fits VW bits.
            remainder <= VW'(w_p_next);
            dbz       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_udiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_udiv
// Purpose  : Self-checking bench for seq_udiv: directed cases plus an
//            exhaustive shuffled sweep with random handshake gaps, checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_udiv;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  int          got_cnt;
  int          sent_cnt;

  seq_udiv #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer division; zero divisor saturates the
  // quotient and returns the low VW dividend bits as remainder.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << DW) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a % (1 << VW) : a % b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an operand pair and return just after the accept edge.
  task automatic send(input int a, input int b, input bit keep_valid);
    int n;
    in_valid = 1'b1;
    dividend = a[DW-1:0];
    divisor  = b[VW-1:0];
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Number of edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input int a, input int b, input string tag);
    int lat;
    send(a, b, 1'b0);
    wait_out(lat);
    check({tag, "_latency"}, lat, (b == 0) ? 0 : DW);
    check({tag, "_quotient"}, quotient, ref_q(a, b));
    check({tag, "_remainder"}, remainder, ref_r(a, b));
    check({tag, "_dbz"}, dbz, (b == 0) ? 1 : 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    int order[4096];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready_after", in_ready, 1);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", dbz, 0);

    // Reset in the middle of the iteration discards the operation.
    send(200, 7, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", dbz, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);

    run_op(225, 15, "basic");
    run_op(200, 7, "rem");
    run_op(255, 1, "div1");
    run_op(173, 0, "dbz");

    // Backpressure with in_valid held high throughout.
    send(100, 9, 1'b1);
    dividend = 8'd50;
    divisor  = 4'd3;
    wait_out(lat);
    check("bp_latency", lat, DW);
    repeat (5) begin
      check("bp_quotient", quotient, 11);
      check("bp_remainder", remainder, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_consumed", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp2_latency", lat, DW);
    check("bp2_quotient", quotient, 16);
    check("bp2_remainder", remainder, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Exhaustive sweep in shuffled order with random gaps on both sides.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    got_cnt  = 0;
    sent_cnt = 0;
    fork
      begin : driver
        for (int k = 0; k < 4096; k++) begin
          int n;
          logic [11:0] pr;
          pr = order[k][11:0];
          repeat ($urandom_range(0, 2)) tick();
          in_valid = 1'b1;
          dividend = pr[7:0];
          divisor  = pr[11:8];
          n = 0;
          while (!in_ready && n < 200) begin
            tick();
            n++;
          end
          if (!in_ready) begin
            check("sweep_accept_timeout", 0, 1);
            in_valid = 1'b0;
            break;
          end
          // in_ready is state-only, so this edge certainly accepts.
          exp_q.push_back(pr);
          tick();
          in_valid = 1'b0;
          sent_cnt++;
        end
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (got_cnt < 4096 && cyc < 90000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("sweep_unexpected_result", 1, 0);
            end else begin
              logic [11:0] pr;
              int a;
              int b;
              pr = exp_q.pop_front();
              a = int'(pr[7:0]);
              b = int'(pr[11:8]);
              check("sweep_quotient", quotient, ref_q(a, b));
              check("sweep_remainder", remainder, ref_r(a, b));
              check("sweep_dbz", dbz, (b == 0) ? 1 : 0);
              if (b != 0) begin
                check("sweep_invariant", int'(quotient) * b + int'(remainder), a);
                check("sweep_rem_lt_div", (int'(remainder) < b) ? 1 : 0, 1);
              end
            end
            got_cnt++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    check("sweep_result_count", got_cnt, sent_cnt);
    check("sweep_all_sent", sent_cnt, 4096);
    check("sweep_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
